post_spike_aer_encoder: RTL

//  Downstream of the post-neuron update stage. Captures each parallel spike vector (one bit per

---
 rtl/post_spike_aer_encoder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/post_spike_aer_encoder.sv
// ---------------------------------------------------------------------------
// post_spike_aer_encoder
//
// Turns parallel post-neuron spike vectors into a stream of neuron addresses
// on a 4-phase REQ/ACK AER port.
//
//   capture reg -> serializer (lowest lane first, one per cycle)
//               -> address FIFO -> AER handshake FSM -> AER_REQ/AER_ADDR
//
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   SPIKE_VLD/RDY    input handshake; vector accepted when VLD && RDY
//   SPIKE_VEC        one spike bit per lane
//   SPIKE_WORD_ADDR  post-neuron SRAM word address of SPIKE_VEC
//   TSTEP_CLR        time-step boundary: clears EVT_CNT and EVT_OVF
//   AER_REQ/ACK      4-phase handshake; AER_ADDR stable while AER_REQ=1
//   FIFO_EMPTY       address FIFO empty
//   ENC_IDLE         nothing captured, nothing queued, handshake idle
//   EVT_CNT/EVT_OVF  saturating count of emitted addresses, sticky overflow
// ---------------------------------------------------------------------------
module post_spike_aer_encoder #(
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_BYTE_ADDR_WIDTH = 2,
  parameter int POST_NEUR_ADDR_WIDTH      = 10,
  parameter int AER_WIDTH                 = 12,
  parameter int FIFO_DEPTH                = 16,
  parameter int EVT_CNT_WIDTH             = 16
) (
  input  logic                                                  CLK,
  input  logic                                                  RST,
  input  logic                                                  SPIKE_VLD,
  output logic                                                  SPIKE_RDY,
  input  logic [POST_NEUR_PARALLEL-1:0]                         SPIKE_VEC,
  input  logic [POST_NEUR_ADDR_WIDTH-POST_NEUR_BYTE_ADDR_WIDTH-1:0] SPIKE_WORD_ADDR,
  input  logic                                                  TSTEP_CLR,
  output logic                                                  AER_REQ,
  input  logic                                                  AER_ACK,
  output logic [AER_WIDTH-1:0]                                  AER_ADDR,
  output logic                                                  FIFO_EMPTY,
  output logic                                                  ENC_IDLE,
  output logic [EVT_CNT_WIDTH-1:0]                              EVT_CNT,
  output logic                                                  EVT_OVF
);

  localparam int WORD_AW = POST_NEUR_ADDR_WIDTH - POST_NEUR_BYTE_ADDR_WIDTH;
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } aer_state_t;

  // ---------------------------------------------------------------- capture
  logic [POST_NEUR_PARALLEL-1:0] cap_vec_reg;
  logic [WORD_AW-1:0]            cap_addr_reg;

  logic                                 push;
  logic                                 pop;
  logic                                 fifo_full;
  logic                                 fifo_empty;
  logic [POST_NEUR_BYTE_ADDR_WIDTH-1:0] low_lane;
  logic [POST_NEUR_ADDR_WIDTH-1:0]      push_addr;

  // The capture register doubles as the pending-bit set: it is "empty"
  // exactly when every bit has been pushed, so a zero vector never blocks.
  assign SPIKE_RDY = (cap_vec_reg == '0);

  // Priority encoder: scanning downwards leaves the lowest set lane.
  always_comb begin
    low_lane = '0;
    for (int i = POST_NEUR_PARALLEL - 1; i >= 0; i--) begin
      if (cap_vec_reg[i]) begin
        low_lane = POST_NEUR_BYTE_ADDR_WIDTH'(i);
      end
    end
  end

  assign push_addr = {cap_addr_reg, low_lane};
  // Push is gated by the registered full flag only; a same-cycle pop does
  // not make room until the next cycle.
  assign push      = (cap_vec_reg != '0) && !fifo_full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_vec_reg  <= '0;
      cap_addr_reg <= '0;
    end else if (SPIKE_VLD && SPIKE_RDY) begin
      cap_vec_reg  <= SPIKE_VEC;
      cap_addr_reg <= SPIKE_WORD_ADDR;
    end else if (push) begin
      // Clear the lowest set bit.
      cap_vec_reg <= cap_vec_reg & (cap_vec_reg - POST_NEUR_PARALLEL'(1));
    end
  end

  // ------------------------------------------------------------------- FIFO
  logic [POST_NEUR_ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW:0]                wr_ptr_reg;
  logic [FIFO_AW:0]                rd_ptr_reg;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                      (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
  assign FIFO_EMPTY = fifo_empty;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[FIFO_AW-1:0]] <= push_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + (FIFO_AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + (FIFO_AW + 1)'(1);
      end
    end
  end

  // --------------------------------------------------------------- AER FSM
  aer_state_t                state_reg;
  logic                      aer_req_reg;
  logic [AER_WIDTH-1:0]      aer_addr_reg;
  logic [EVT_CNT_WIDTH-1:0]  evt_cnt_reg;
  logic                      evt_ovf_reg;
  logic                      evt_done;

  assign pop      = (state_reg == ST_IDLE) && !fifo_empty;
  assign evt_done = (state_reg == ST_REQ) && AER_ACK;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      aer_req_reg  <= 1'b0;
      aer_addr_reg <= '0;
      evt_cnt_reg  <= '0;
      evt_ovf_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            // Head is captured straight into the output register.
            aer_addr_reg <= AER_WIDTH'(fifo_mem[rd_ptr_reg[FIFO_AW-1:0]]);
            aer_req_reg  <= 1'b1;
            state_reg    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (AER_ACK) begin
            aer_req_reg <= 1'b0;
            state_reg   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (!AER_ACK) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // A time-step clear wins over an event completing in the same cycle.
      if (TSTEP_CLR) begin
        evt_cnt_reg <= '0;
        evt_ovf_reg <= 1'b0;
      end else if (evt_done) begin
        if (evt_cnt_reg == '1) begin
          evt_ovf_reg <= 1'b1;
        end else begin
          evt_cnt_reg <= evt_cnt_reg + EVT_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign AER_REQ  = aer_req_reg;
  assign AER_ADDR = aer_addr_reg;
  assign EVT_CNT  = evt_cnt_reg;
  assign EVT_OVF  = evt_ovf_reg;
  assign ENC_IDLE = SPIKE_RDY && fifo_empty && (state_reg == ST_IDLE);

endmodule
